vid_blit: RTL and testbench

VID_BLIT -- requirements
Module: vid_blit

---
 rtl/vid_pkg.sv | 37 +++
 rtl/vid_blit.sv | 216 +++++++++++++++++++++
 tb/tb_vid_blit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// ============================================================================
// Module      : vid_pkg
// Description : Shared register map, ctrl/status bit positions and FSM
//               encoding for the vid_blit fill/copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vid_pkg;

  localparam logic [2:0] c_reg_dst_lo = 3'd0;
  localparam logic [2:0] c_reg_dst_hi = 3'd1;
  localparam logic [2:0] c_reg_src_lo = 3'd2;
  localparam logic [2:0] c_reg_src_hi = 3'd3;
  localparam logic [2:0] c_reg_len_lo = 3'd4;
  localparam logic [2:0] c_reg_len_hi = 3'd5;
  localparam logic [2:0] c_reg_fill   = 3'd6;
  localparam logic [2:0] c_reg_ctrl   = 3'd7;

  localparam int c_ctrl_fill  = 0;
  localparam int c_ctrl_copy  = 1;
  localparam int c_ctrl_ie    = 2;
  localparam int c_ctrl_abort = 3;
  localparam int c_ctrl_clr   = 7;

  localparam int c_stat_busy = 0;
  localparam int c_stat_done = 1;
  localparam int c_stat_ie   = 2;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fill  = 2'd1;
  localparam logic [1:0] c_st_cp_rd = 2'd2;
  localparam logic [1:0] c_st_cp_wr = 2'd3;

endpackage

`default_nettype wire

// File: rtl/vid_blit.sv
// ============================================================================
// Module      : vid_blit
// Description : Video RAM fill/copy blitter with CPU-priority RAM port mux.
//               Copy mode is compiled in by defining VID_BLIT_COPY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_blit
  import vid_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel_reg,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          cpu_sel_ram,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          v_sel_ram,
  output logic          v_we,
  output logic [AW-1:0] v_addr,
  output logic [7:0]    v_din,
  input  logic [7:0]    v_ram_dout,
  output logic          busy,
  output logic          irq
);

  logic [1:0]    r_state;
  logic [15:0]   r_dst;
  logic [15:0]   r_len;
  logic [7:0]    r_fill;
  logic [7:0]    r_dout;
  logic          r_done;
  logic          r_ie;
  logic          r_irq;
  logic          w_busy;
  logic          w_ctrl_wr;
  logic          w_cfg_wr;
  logic          w_abort;
  logic          w_kill;
  logic          w_step;
  logic          w_last;
  logic          w_start_fill;
  logic          w_start_copy;
  logic          w_eng_sel;
  logic          w_eng_we;
  logic [AW-1:0] w_eng_addr;
  logic [7:0]    w_eng_din;
  logic [7:0]    w_rd_data;
  logic [7:0]    w_status;

`ifdef VID_BLIT_COPY_EN
  logic [15:0]   r_src;
`else
  logic          w_unused_ram;
  assign w_unused_ram = ^v_ram_dout;
`endif

  assign w_busy       = (r_state != c_st_idle);
  assign w_ctrl_wr    = sel_reg & we & (addr == c_reg_ctrl);
  assign w_cfg_wr     = sel_reg & we & ~w_busy;
  assign w_abort      = w_ctrl_wr & din[c_ctrl_abort] & w_busy;
  // Reset and abort both suppress the in-flight engine access immediately.
  assign w_kill       = reset | w_abort;
  assign w_step       = ~cpu_sel_ram & ~w_kill;
  assign w_last       = (r_len == 16'd1);
  assign w_start_fill = w_ctrl_wr & ~w_busy & din[c_ctrl_fill];
`ifdef VID_BLIT_COPY_EN
  assign w_start_copy = w_ctrl_wr & ~w_busy & ~din[c_ctrl_fill] & din[c_ctrl_copy];
`else
  assign w_start_copy = 1'b0;
`endif

  always_comb begin
    w_eng_sel  = 1'b0;
    w_eng_we   = 1'b0;
    w_eng_addr = r_dst[AW-1:0];
    w_eng_din  = r_fill;
    case (r_state)
      c_st_fill: begin
        w_eng_sel = 1'b1;
        w_eng_we  = 1'b1;
      end
`ifdef VID_BLIT_COPY_EN
      c_st_cp_rd: begin
        w_eng_sel  = 1'b1;
        w_eng_addr = r_src[AW-1:0];
      end
      c_st_cp_wr: begin
        w_eng_sel = 1'b1;
        w_eng_we  = 1'b1;
        w_eng_din = v_ram_dout;
      end
`endif
      default: ;
    endcase
    if (w_kill) begin
      w_eng_sel = 1'b0;
      w_eng_we  = 1'b0;
    end
  end

  assign v_sel_ram = cpu_sel_ram | w_eng_sel;
  assign v_we      = cpu_sel_ram ? cpu_we   : w_eng_we;
  assign v_addr    = cpu_sel_ram ? cpu_addr : w_eng_addr;
  assign v_din     = cpu_sel_ram ? cpu_din  : w_eng_din;

  always_comb begin
    w_status              = 8'h00;
    w_status[c_stat_busy] = w_busy;
    w_status[c_stat_done] = r_done;
    w_status[c_stat_ie]   = r_ie;
    w_rd_data             = 8'h00;
    case (addr)
      c_reg_dst_lo: w_rd_data = r_dst[7:0];
      c_reg_dst_hi: w_rd_data = r_dst[15:8];
`ifdef VID_BLIT_COPY_EN
      c_reg_src_lo: w_rd_data = r_src[7:0];
      c_reg_src_hi: w_rd_data = r_src[15:8];
`endif
      c_reg_len_lo: w_rd_data = r_len[7:0];
      c_reg_len_hi: w_rd_data = r_len[15:8];
      c_reg_fill:   w_rd_data = r_fill;
      c_reg_ctrl:   w_rd_data = w_status;
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_dst   <= 16'h0000;
      r_len   <= 16'h0000;
      r_fill  <= 8'h00;
      r_dout  <= 8'h00;
      r_done  <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
`ifdef VID_BLIT_COPY_EN
      r_src   <= 16'h0000;
`endif
    end else begin
      r_irq <= r_done & r_ie;
      if (sel_reg && !we) r_dout <= w_rd_data;

      if (w_cfg_wr) begin
        case (addr)
          c_reg_dst_lo: r_dst[7:0]  <= din;
          c_reg_dst_hi: r_dst[15:8] <= din;
`ifdef VID_BLIT_COPY_EN
          c_reg_src_lo: r_src[7:0]  <= din;
          c_reg_src_hi: r_src[15:8] <= din;
`endif
          c_reg_len_lo: r_len[7:0]  <= din;
          c_reg_len_hi: r_len[15:8] <= din;
          c_reg_fill:   r_fill      <= din;
          default: ;
        endcase
      end

      if (w_ctrl_wr) begin
        r_ie <= din[c_ctrl_ie];
        if (din[c_ctrl_clr]) r_done <= 1'b0;
      end

      // A zero-length start completes on the spot.
      if (w_start_fill || w_start_copy) begin
        r_done <= (r_len == 16'h0000);
        if (r_len != 16'h0000) r_state <= w_start_fill ? c_st_fill : c_st_cp_rd;
      end

      if (w_abort) begin
        r_state <= c_st_idle;
        r_done  <= 1'b1;
      end else if (w_step) begin
        case (r_state)
          c_st_fill: begin
            r_dst[AW-1:0] <= r_dst[AW-1:0] + 1'b1;
            r_len         <= r_len - 16'd1;
            if (w_last) begin
              r_state <= c_st_idle;
              r_done  <= 1'b1;
            end
          end
`ifdef VID_BLIT_COPY_EN
          c_st_cp_rd: r_state <= c_st_cp_wr;
          c_st_cp_wr: begin
            r_src[AW-1:0] <= r_src[AW-1:0] + 1'b1;
            r_dst[AW-1:0] <= r_dst[AW-1:0] + 1'b1;
            r_len         <= r_len - 16'd1;
            r_state       <= w_last ? c_st_idle : c_st_cp_rd;
            if (w_last) r_done <= 1'b1;
          end
`endif
          default: ;
        endcase
      end else if (cpu_sel_ram && r_state == c_st_cp_wr) begin
        // Read data was lost to the CPU access; fetch it again.
        r_state <= c_st_cp_rd;
      end
    end
  end

  assign dout = r_dout;
  assign busy = w_busy;
  assign irq  = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_vid_blit.sv
// ============================================================================
// Module      : tb_vid_blit
// Description : Directed self-checking bench for vid_blit with a byte RAM
//               model and a log of every RAM write seen on the v_* port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vid_blit;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_reg;
  logic          we;
  logic [2:0]    addr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          cpu_sel_ram;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          v_sel_ram;
  logic          v_we;
  logic [AW-1:0] v_addr;
  logic [7:0]    v_din;
  logic [7:0]    v_ram_dout;
  logic          busy;
  logic          irq;

  always #5 clk = ~clk;

  vid_blit #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .sel_reg(sel_reg), .we(we), .addr(addr), .din(din), .dout(dout),
    .cpu_sel_ram(cpu_sel_ram), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .v_sel_ram(v_sel_ram), .v_we(v_we), .v_addr(v_addr), .v_din(v_din),
    .v_ram_dout(v_ram_dout), .busy(busy), .irq(irq)
  );

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (v_sel_ram && v_we)  mem[v_addr] <= v_din;
    if (v_sel_ram && !v_we) v_ram_dout  <= mem[v_addr];
  end

  int cyc = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (v_sel_ram && v_we) begin
      log_addr.push_back(int'(v_addr));
      log_data.push_back(int'(v_din));
      log_cyc.push_back(cyc);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sel_reg = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    sel_reg = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    sel_reg = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel_reg = 1'b0;
    d = dout;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_sel_ram = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    @(posedge clk); #1;
    cpu_sel_ram = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic set_op(input logic [15:0] dst, input logic [15:0] len, input logic [7:0] fill);
    reg_wr(3'd0, dst[7:0]); reg_wr(3'd1, dst[15:8]);
    reg_wr(3'd4, len[7:0]); reg_wr(3'd5, len[15:8]);
    reg_wr(3'd6, fill);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int n_before;
    int k;
    reset = 1'b1; sel_reg = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    cpu_sel_ram = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
    idle(3);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_vsel", v_sel_ram, 0);
    check("rst_dout", dout, 0);
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), d);
      check($sformatf("rst_reg%0d", i), d, 0);
    end

    // Zero-length start: done immediately, no RAM traffic
    clear_log();
    reg_wr(3'd7, 8'h01);
    idle(2);
    reg_rd(3'd7, d);
    check("len0_status", d, 8'h02);
    check("len0_writes", log_addr.size(), 0);
    reg_wr(3'd7, 8'h80);
    reg_rd(3'd7, d);
    check("clr_done_status", d, 8'h00);

    // Basic fill of 4 bytes at 0x0100
    set_op(16'h0100, 16'd4, 8'hAA);
    clear_log();
    reg_wr(3'd7, 8'h01);
    idle(6);
    check("fill_count", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check($sformatf("fill_addr%0d", i), log_addr[i], 32'h100 + i);
      check($sformatf("fill_data%0d", i), log_data[i], 32'hAA);
      check($sformatf("fill_cyc%0d", i), log_cyc[i] - log_cyc[0], i);
    end
    check("fill_mem103", mem[13'h103], 8'hAA);
    reg_rd(3'd7, d);
    check("fill_status", d, 8'h02);

    // Fill of 3 with a CPU write stealing the 2nd cycle
    set_op(16'h0200, 16'd3, 8'h55);
    clear_log();
    reg_wr(3'd7, 8'h01);
    @(posedge clk); #1;
    cpu_sel_ram = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_din = 8'h77;
    #1;
    check("pre_vaddr", v_addr, 13'h0300);
    @(posedge clk); #1;
    cpu_sel_ram = 1'b0; cpu_we = 1'b0;
    idle(5);
    check("pre_count", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("pre_a0", log_addr[0], 32'h200); check("pre_d0", log_data[0], 32'h55);
      check("pre_a1", log_addr[1], 32'h300); check("pre_d1", log_data[1], 32'h77);
      check("pre_a2", log_addr[2], 32'h201); check("pre_a3", log_addr[3], 32'h202);
      check("pre_span", log_cyc[3] - log_cyc[0], 3);
    end

    // Address wrap at the top of the window
    set_op(16'h1FFF, 16'd2, 8'h5A);
    clear_log();
    reg_wr(3'd7, 8'h01);
    idle(5);
    check("wrap_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("wrap_a0", log_addr[0], 32'h1FFF);
      check("wrap_a1", log_addr[1], 32'h0000);
    end
    reg_rd(3'd0, d);
    check("wrap_dst_lo", d, 8'h01);
    reg_rd(3'd1, d);
    check("wrap_dst_hi", d, 8'h00);

`ifdef VID_BLIT_COPY_EN
    cpu_wr(13'h0000, 8'h11);
    cpu_wr(13'h0001, 8'h22);
    reg_wr(3'd2, 8'h00); reg_wr(3'd3, 8'h00);
    set_op(16'h0400, 16'd2, 8'h00);
    clear_log();
    reg_wr(3'd7, 8'h02);
    idle(6);
    check("copy_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("copy_a0", log_addr[0], 32'h400); check("copy_d0", log_data[0], 32'h11);
      check("copy_a1", log_addr[1], 32'h401); check("copy_d1", log_data[1], 32'h22);
      check("copy_span", log_cyc[1] - log_cyc[0], 2);
    end
    check("copy_mem401", mem[13'h401], 8'h22);
`else
    // Copy not built in: start copy does nothing and src reads 0
    reg_wr(3'd2, 8'h55);
    reg_rd(3'd2, d);
    check("nocopy_src", d, 8'h00);
    set_op(16'h0400, 16'd2, 8'h00);
    clear_log();
    reg_wr(3'd7, 8'h02);
    idle(3);
    check("nocopy_busy", busy, 0);
    check("nocopy_writes", log_addr.size(), 0);
`endif

    // Long fill aborted after exactly 10 writes, irq enabled
    set_op(16'h0800, 16'h0100, 8'h3C);
    clear_log();
    reg_wr(3'd7, 8'h05);
    k = 0;
    while (log_addr.size() < 10 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("abort_reach10", log_addr.size() >= 10, 1);
    #1;
    sel_reg = 1'b1; we = 1'b1; addr = 3'd7; din = 8'h0C;
    @(posedge clk); #1;
    sel_reg = 1'b0; we = 1'b0;
    idle(4);
    check("abort_count", log_addr.size(), 10);
    reg_rd(3'd7, d);
    check("abort_status", d, 8'h06);
    check("abort_irq", irq, 1);

    // Reset in the middle of a transfer
`ifdef VID_BLIT_COPY_EN
    reg_wr(3'd2, 8'h00); reg_wr(3'd3, 8'h00);
    set_op(16'h0500, 16'd8, 8'h00);
    reg_wr(3'd7, 8'h06);
`else
    set_op(16'h0500, 16'h0040, 8'h99);
    reg_wr(3'd7, 8'h05);
`endif
    idle(2);
    check("mid_busy", busy, 1);
    n_before = log_addr.size();
    reset = 1'b1;
    #1;
    check("rst_mid_vsel_now", v_sel_ram, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_vsel", v_sel_ram, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_irq", irq, 0);
    idle(2);
    check("rst_mid_writes", log_addr.size(), n_before);
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), d);
      check($sformatf("rst_mid_reg%0d", i), d, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
